cpu_ctrl_fsm: RTL and testbench

//  Moore controller that sequences the datapath for one instruction per start (s) pulse.

---
 rtl/cpu_ctrl_fsm_pkg.sv | 99 +++++++++
 rtl/cpu_ctrl_fsm_if.sv | 37 +++
 rtl/cpu_ctrl_fsm_mem_timeout_ctr.sv | 34 +++
 rtl/cpu_ctrl_fsm.sv | 113 +++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the instruction-sequencing controller: state codes,
// opcode/sub-op constants, writeback and register-select codes, and the
// per-state output decode.
package cpu_ctrl_fsm_pkg;

  typedef logic [2:0] opcode_t;
  typedef logic [1:0] op_t;
  typedef logic [1:0] vsel_t;
  typedef logic [2:0] nsel_t;

  // Seventeen states have distinct Moore outputs, so the code needs 5 bits.
  typedef logic [4:0] state_t;

  localparam state_t S_WAIT    = 5'd0;
  localparam state_t S_DECODE  = 5'd1;
  localparam state_t S_WR_IMM  = 5'd2;
  localparam state_t S_GET_A   = 5'd3;
  localparam state_t S_GET_B   = 5'd4;
  localparam state_t S_ALU     = 5'd5;
  localparam state_t S_ALU_A   = 5'd6;   // A operand forced to 0; also serves as ST_C
  localparam state_t S_WR_REG  = 5'd7;
  localparam state_t S_CMP     = 5'd8;
  localparam state_t S_ADDR    = 5'd9;
  localparam state_t S_LD_ADDR = 5'd10;
  localparam state_t S_MEM_RD  = 5'd11;
  localparam state_t S_WR_MEM  = 5'd12;
  localparam state_t S_GET_D   = 5'd13;
  localparam state_t S_MEM_WR  = 5'd14;
  localparam state_t S_HALT    = 5'd15;
  localparam state_t S_ERR     = 5'd16;

  localparam opcode_t OPC_LDR  = 3'b011;
  localparam opcode_t OPC_STR  = 3'b100;
  localparam opcode_t OPC_ALU  = 3'b101;
  localparam opcode_t OPC_MOV  = 3'b110;
  localparam opcode_t OPC_HALT = 3'b111;

  localparam op_t OP_MOV_REG = 2'b00;
  localparam op_t OP_MOV_IMM = 2'b10;
  localparam op_t OP_CMP     = 2'b01;
  localparam op_t OP_MVN     = 2'b11;
  localparam op_t OP_MEM     = 2'b00;

  localparam vsel_t VSEL_C   = 2'b00;
  localparam vsel_t VSEL_IMM = 2'b01;
  localparam vsel_t VSEL_MEM = 2'b10;

  localparam nsel_t NSEL_NONE = 3'b000;
  localparam nsel_t NSEL_RN   = 3'b001;
  localparam nsel_t NSEL_RD   = 3'b010;
  localparam nsel_t NSEL_RM   = 3'b100;

  typedef struct packed {
    logic  w;
    logic  loada;
    logic  loadb;
    logic  loadc;
    logic  loads;
    logic  asel;
    logic  bsel;
    vsel_t vsel;
    nsel_t nsel;
    logic  write;
    logic  load_addr;
    logic  mem_req;
    logic  mem_we;
    logic  err;
    logic  halted;
  } ctrl_out_t;

  // Moore output decode; unlisted codes drive all-zero controls.
  function automatic ctrl_out_t state_outputs(input state_t st);
    ctrl_out_t o;
    o      = '0;
    o.vsel = VSEL_C;
    o.nsel = NSEL_NONE;
    case (st)
      S_WAIT:    o.w = 1'b1;
      S_WR_IMM:  begin o.vsel = VSEL_IMM; o.nsel = NSEL_RN; o.write = 1'b1; end
      S_GET_A:   begin o.nsel = NSEL_RN; o.loada = 1'b1; end
      S_GET_B:   begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
      S_ALU:     o.loadc = 1'b1;
      S_ALU_A:   begin o.asel = 1'b1; o.loadc = 1'b1; end
      S_WR_REG:  begin o.vsel = VSEL_C; o.nsel = NSEL_RD; o.write = 1'b1; end
      S_CMP:     o.loads = 1'b1;
      S_ADDR:    begin o.bsel = 1'b1; o.loadc = 1'b1; end
      S_LD_ADDR: o.load_addr = 1'b1;
      S_MEM_RD:  o.mem_req = 1'b1;
      S_WR_MEM:  begin o.vsel = VSEL_MEM; o.nsel = NSEL_RD; o.write = 1'b1; end
      S_GET_D:   begin o.nsel = NSEL_RD; o.loadb = 1'b1; end
      S_MEM_WR:  begin o.mem_req = 1'b1; o.mem_we = 1'b1; end
      S_HALT:    o.halted = 1'b1;
      S_ERR:     o.err = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Decode-side inputs and datapath/memory control outputs of the controller.
interface cpu_ctrl_fsm_if;
  import cpu_ctrl_fsm_pkg::*;

  logic    s;
  opcode_t opcode;
  op_t     op;
  logic    mem_ack;

  logic    w;
  logic    loada;
  logic    loadb;
  logic    loadc;
  logic    loads;
  logic    asel;
  logic    bsel;
  vsel_t   vsel;
  nsel_t   nsel;
  logic    write;
  logic    load_addr;
  logic    mem_req;
  logic    mem_we;
  logic    err;
  logic    halted;

  modport master (
    input  s, opcode, op, mem_ack,
    output w, loada, loadb, loadc, loads, asel, bsel, vsel, nsel,
           write, load_addr, mem_req, mem_we, err, halted
  );

  modport slave (
    output s, opcode, op, mem_ack,
    input  w, loada, loadb, loadc, loads, asel, bsel, vsel, nsel,
           write, load_addr, mem_req, mem_we, err, halted
  );
endinterface

// File: rtl/cpu_ctrl_fsm_mem_timeout_ctr.sv
// Counts memory-wait cycles without acknowledge; flags the cycle on which
// the LIMIT-th unacknowledged cycle occurs.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;

  // Clear has priority; otherwise count each enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == 8'(LIMIT - 1));
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Moore controller sequencing one instruction per start pulse, with a
// req/ack memory handshake, timeout, halt and illegal-opcode reporting.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter bit          MEM_EN  = 1'b1,
  parameter int unsigned MEM_TO  = 15,
  parameter bit          HALT_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  cpu_ctrl_fsm_if.master bus
);
  state_t    state_q, state_d;
  logic [4:0] instr_q, instr_d;
  opcode_t   opc_q;
  op_t       op_q;
  logic      in_mem;
  logic      tmo_expired;
  ctrl_out_t out_s;

  assign opc_q  = instr_q[4:2];
  assign op_q   = instr_q[1:0];
  assign in_mem = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mem_timeout_ctr #(.LIMIT(MEM_TO)) u_tmo (
    .clk       (clk),
    .rst_n     (reset_n),
    .clr_i     (!in_mem || bus.mem_ack),
    .en_i      (in_mem && !bus.mem_ack),
    .expired_o (tmo_expired)
  );

  // State and captured instruction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic. The instruction is captured in DECODE so later
  // branch points (shared GET_A/GET_B/ALU_A states) can tell paths apart.
  always_comb begin
    state_d = S_WAIT;
    instr_d = instr_q;
    case (state_q)
      S_WAIT:   state_d = bus.s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        instr_d = {bus.opcode, bus.op};
        case (bus.opcode)
          OPC_MOV:
            if (bus.op == OP_MOV_IMM)      state_d = S_WR_IMM;
            else if (bus.op == OP_MOV_REG) state_d = S_GET_B;
            else                           state_d = S_ERR;
          OPC_ALU:
            state_d = (bus.op == OP_MVN) ? S_GET_B : S_GET_A;
          OPC_LDR, OPC_STR:
            state_d = (MEM_EN && bus.op == OP_MEM) ? S_GET_A : S_ERR;
          OPC_HALT:
            state_d = HALT_EN ? S_HALT : S_ERR;
          default:
            state_d = S_ERR;
        endcase
      end
      S_GET_A:
        state_d = (opc_q == OPC_LDR || opc_q == OPC_STR) ? S_ADDR : S_GET_B;
      S_GET_B:
        if (opc_q == OPC_ALU && op_q == OP_CMP)      state_d = S_CMP;
        else if (opc_q == OPC_ALU && op_q != OP_MVN) state_d = S_ALU;
        else                                         state_d = S_ALU_A;
      S_ALU:     state_d = S_WR_REG;
      S_ALU_A:   state_d = (opc_q == OPC_STR) ? S_MEM_WR : S_WR_REG;
      S_ADDR:    state_d = S_LD_ADDR;
      S_LD_ADDR: state_d = (opc_q == OPC_STR) ? S_GET_D : S_MEM_RD;
      S_GET_D:   state_d = S_ALU_A;
      S_MEM_RD:
        if (bus.mem_ack)      state_d = S_WR_MEM;
        else if (tmo_expired) state_d = S_ERR;
        else                  state_d = S_MEM_RD;
      S_MEM_WR:
        if (bus.mem_ack)      state_d = S_WAIT;
        else if (tmo_expired) state_d = S_ERR;
        else                  state_d = S_MEM_WR;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_WAIT;
    endcase
  end

  // Output decode from the current state only.
  always_comb begin
    out_s = state_outputs(state_q);
  end

  assign bus.w         = out_s.w;
  assign bus.loada     = out_s.loada;
  assign bus.loadb     = out_s.loadb;
  assign bus.loadc     = out_s.loadc;
  assign bus.loads     = out_s.loads;
  assign bus.asel      = out_s.asel;
  assign bus.bsel      = out_s.bsel;
  assign bus.vsel      = out_s.vsel;
  assign bus.nsel      = out_s.nsel;
  assign bus.write     = out_s.write;
  assign bus.load_addr = out_s.load_addr;
  assign bus.mem_req   = out_s.mem_req;
  assign bus.mem_we    = out_s.mem_we;
  assign bus.err       = out_s.err;
  assign bus.halted    = out_s.halted;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: one instance with memory/halt enabled, one with
// both gated off; expected per-cycle controls come from an instruction-level
// model of the sequencing rules.
module tb_cpu_ctrl_fsm;

  localparam int MTO = 15;

  typedef struct packed {
    logic       w;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [2:0] nsel;
    logic       write;
    logic       load_addr;
    logic       mem_req;
    logic       mem_we;
    logic       err;
    logic       halted;
  } outv_t;

  typedef struct {
    bit         which;
    logic [2:0] opc;
    logic [1:0] op;
    int         k;
    int         lat;
    int         errs;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   passed = 0;
  int   total  = 0;
  outv_t exp_q[$];

  always #5 clk = ~clk;

  cpu_ctrl_fsm_if bus0 ();
  cpu_ctrl_fsm_if bus1 ();

  cpu_ctrl_fsm #(.MEM_EN(1'b1), .MEM_TO(MTO), .HALT_EN(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.master));
  cpu_ctrl_fsm #(.MEM_EN(1'b0), .MEM_TO(MTO), .HALT_EN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.master));

  function automatic outv_t get_out(input bit which);
    outv_t v;
    if (which)
      v = {bus1.w, bus1.loada, bus1.loadb, bus1.loadc, bus1.loads, bus1.asel,
           bus1.bsel, bus1.vsel, bus1.nsel, bus1.write, bus1.load_addr,
           bus1.mem_req, bus1.mem_we, bus1.err, bus1.halted};
    else
      v = {bus0.w, bus0.loada, bus0.loadb, bus0.loadc, bus0.loads, bus0.asel,
           bus0.bsel, bus0.vsel, bus0.nsel, bus0.write, bus0.load_addr,
           bus0.mem_req, bus0.mem_we, bus0.err, bus0.halted};
    return v;
  endfunction

  task automatic check_vec(input string name, input int cyc, input outv_t act, input outv_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s got=%0d want=%0d", name, act, exp);
  endtask

  // Instruction-level reference: list of control vectors, one per cycle,
  // starting with the cycle in which s is presented.
  function automatic void model(input logic [2:0] opc, input logic [1:0] sop,
                                input bit memen, input bit halten, input int k);
    outv_t z, v;
    int n;
    z = '0;
    exp_q.delete();
    v = z; v.w = 1; exp_q.push_back(v);          // idle, s accepted
    exp_q.push_back(z);                          // decode
    if (opc == 3'b110 && sop == 2'b10) begin
      v = z; v.vsel = 2'b01; v.nsel = 3'b001; v.write = 1; exp_q.push_back(v);
    end else if ((opc == 3'b110 && sop == 2'b00) || (opc == 3'b101 && sop == 2'b11)) begin
      v = z; v.nsel = 3'b100; v.loadb = 1; exp_q.push_back(v);
      v = z; v.asel = 1; v.loadc = 1; exp_q.push_back(v);
      v = z; v.nsel = 3'b010; v.write = 1; exp_q.push_back(v);
    end else if (opc == 3'b101) begin
      v = z; v.nsel = 3'b001; v.loada = 1; exp_q.push_back(v);
      v = z; v.nsel = 3'b100; v.loadb = 1; exp_q.push_back(v);
      if (sop == 2'b01) begin
        v = z; v.loads = 1; exp_q.push_back(v);
      end else begin
        v = z; v.loadc = 1; exp_q.push_back(v);
        v = z; v.nsel = 3'b010; v.write = 1; exp_q.push_back(v);
      end
    end else if (memen && sop == 2'b00 && (opc == 3'b011 || opc == 3'b100)) begin
      v = z; v.nsel = 3'b001; v.loada = 1; exp_q.push_back(v);
      v = z; v.bsel = 1; v.loadc = 1; exp_q.push_back(v);
      v = z; v.load_addr = 1; exp_q.push_back(v);
      if (opc == 3'b100) begin
        v = z; v.nsel = 3'b010; v.loadb = 1; exp_q.push_back(v);
        v = z; v.asel = 1; v.loadc = 1; exp_q.push_back(v);
      end
      n = (k < MTO) ? k + 1 : MTO;
      for (int i = 0; i < n; i++) begin
        v = z; v.mem_req = 1; v.mem_we = (opc == 3'b100); exp_q.push_back(v);
      end
      if (k >= MTO) begin
        v = z; v.err = 1; exp_q.push_back(v);
      end else if (opc == 3'b011) begin
        v = z; v.vsel = 2'b10; v.nsel = 3'b010; v.write = 1; exp_q.push_back(v);
      end
    end else if (halten && opc == 3'b111) begin
      for (int i = 0; i < 20; i++) begin
        v = z; v.halted = 1; exp_q.push_back(v);
      end
      return;
    end else begin
      v = z; v.err = 1; exp_q.push_back(v);
    end
    v = z; v.w = 1; exp_q.push_back(v);
  endfunction

  task automatic drive(input bit which, input logic s_v, input logic ack_v);
    if (which) begin bus1.s = s_v; bus1.mem_ack = ack_v; end
    else       begin bus0.s = s_v; bus0.mem_ack = ack_v; end
  endtask

  task automatic set_op(input bit which, input logic [2:0] o, input logic [1:0] p);
    if (which) begin bus1.opcode = o; bus1.op = p; end
    else       begin bus0.opcode = o; bus0.op = p; end
  endtask

  task automatic do_reset();
    outv_t wv;
    wv = '0; wv.w = 1;
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    #2;
    check_vec("reset0", 0, get_out(0), wv);
    check_vec("reset1", 0, get_out(1), wv);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a falling edge with the selected DUT idle.
  task automatic run(input bit which, input logic [2:0] opc, input logic [1:0] sop,
                     input int k, output int lat, output int errs);
    outv_t a;
    logic  s_v, ack_v;
    int    memidx;
    string name;
    name = $sformatf("dut%0d_%b_%b_k%0d", which, opc, sop, k);
    model(opc, sop, !which, !which, k);
    lat = 0; errs = 0; memidx = 0;
    set_op(which, opc, sop);
    for (int i = 0; i < exp_q.size(); i++) begin
      a = get_out(which);
      check_vec(name, i, a, exp_q[i]);
      if (i > 0 && a.w && lat == 0) lat = i;
      if (a.err) errs++;
      if (i == 0)            s_v = 1'b1;
      else if (exp_q[i].w)   s_v = 1'b0;
      else                   s_v = 1'($urandom_range(0, 1));
      if (exp_q[i].mem_req) begin
        ack_v = (memidx == k);
        memidx++;
      end else begin
        ack_v = 1'($urandom_range(0, 1));
      end
      drive(which, s_v, ack_v);
      @(negedge clk);
    end
    drive(which, 1'b0, 1'b0);
    if (exp_q[exp_q.size()-1].halted) do_reset();
  endtask

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int    lat, errs;
    outv_t wv;
    wv = '0; wv.w = 1;

    tbl[0]  = '{0, 3'b110, 2'b10, 0,  3,  0};   // MOV imm
    tbl[1]  = '{0, 3'b110, 2'b00, 0,  5,  0};   // MOV reg
    tbl[2]  = '{0, 3'b101, 2'b00, 0,  6,  0};   // ADD
    tbl[3]  = '{0, 3'b101, 2'b10, 0,  6,  0};   // AND
    tbl[4]  = '{0, 3'b101, 2'b01, 0,  5,  0};   // CMP
    tbl[5]  = '{0, 3'b101, 2'b11, 0,  5,  0};   // MVN
    tbl[6]  = '{0, 3'b011, 2'b00, 2,  9,  0};   // LDR, two wait cycles
    tbl[7]  = '{0, 3'b011, 2'b00, 0,  7,  0};   // LDR, immediate ack
    tbl[8]  = '{0, 3'b100, 2'b00, 99, 23, 1};   // STR, no ack -> timeout
    tbl[9]  = '{0, 3'b100, 2'b00, 14, 22, 0};   // STR, ack on 15th MEM cycle
    tbl[10] = '{0, 3'b011, 2'b00, 99, 21, 1};   // LDR timeout
    tbl[11] = '{0, 3'b001, 2'b00, 0,  3,  1};   // illegal opcode
    tbl[12] = '{0, 3'b110, 2'b01, 0,  3,  1};   // illegal MOV sub-op
    tbl[13] = '{0, 3'b011, 2'b01, 0,  3,  1};   // illegal LDR sub-op
    tbl[14] = '{1, 3'b011, 2'b00, 0,  3,  1};   // LDR with memory gated off
    tbl[15] = '{1, 3'b100, 2'b00, 0,  3,  1};   // STR with memory gated off
    tbl[16] = '{1, 3'b111, 2'b00, 0,  3,  1};   // HALT gated off
    tbl[17] = '{1, 3'b101, 2'b00, 0,  6,  0};   // ADD on gated instance

    set_op(0, 3'b000, 2'b00);
    set_op(1, 3'b000, 2'b00);
    do_reset();

    // Asynchronous reset in the middle of ADD (GET_B cycle).
    model(3'b101, 2'b00, 1'b1, 1'b1, 0);
    set_op(0, 3'b101, 2'b00);
    for (int i = 0; i <= 3; i++) begin
      check_vec("add_pre_reset", i, get_out(0), exp_q[i]);
      drive(0, (i == 0), 1'b0);
      if (i != 3) @(negedge clk);
    end
    #1 reset_n = 1'b0;
    #1 check_vec("async_reset", 0, get_out(0), wv);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("after_reset_idle", i, get_out(0), wv);
    end

    for (int r = 0; r < 18; r++) begin
      run(tbl[r].which, tbl[r].opc, tbl[r].op, tbl[r].k, lat, errs);
      check_int($sformatf("latency_row%0d", r), lat, tbl[r].lat);
      check_int($sformatf("errcount_row%0d", r), errs, tbl[r].errs);
    end

    // HALT: held for 20 cycles with s toggling, then reset.
    run(0, 3'b111, 2'b10, 0, lat, errs);
    check_int("halt_no_err", errs, 0);

    for (int r = 0; r < 40; r++) begin
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          int'($urandom_range(0, 17)), lat, errs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
